// File: rtl/weight_mem_ctrl_pkg.sv
// rtl/weight_mem_ctrl_pkg.sv - shared types and helpers for the weight memory controller
package weight_mem_ctrl_pkg;

    // Width of the layer / neuron identifiers carried on the config bus
    localparam int CFG_ID_W = 8;

    // IDLE: inference allowed, first weight of a reload may arrive; LOAD: mid-reload
    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Bits needed to index n entries (never less than one bit)
    function automatic int addr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_mem_ctrl_if.sv
// rtl/weight_mem_ctrl_if.sv - config, input-stream, memory-port and MAC-side signals of one neuron
interface weight_mem_ctrl_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    import weight_mem_ctrl_pkg::*;

    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [CFG_ID_W-1:0]     cfg_layer;
    logic [CFG_ID_W-1:0]     cfg_neuron;
    logic [dataWidth-1:0]    cfg_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [dataWidth-1:0]    in_data;
    logic                    wen;
    logic [addressWidth-1:0] wadd;
    logic [dataWidth-1:0]    win;
    logic                    ren;
    logic [addressWidth-1:0] radd;
    logic                    mac_valid;
    logic [dataWidth-1:0]    mac_data;
    logic                    mac_last;
    logic                    loaded;
    logic                    busy;

    // Side that sources config and input beats and consumes memory / MAC signals
    modport master (
        output cfg_valid, cfg_layer, cfg_neuron, cfg_data, in_valid, in_data,
        input  cfg_ready, in_ready, wen, wadd, win, ren, radd,
               mac_valid, mac_data, mac_last, loaded, busy
    );

    // The controller itself
    modport slave (
        input  cfg_valid, cfg_layer, cfg_neuron, cfg_data, in_valid, in_data,
        output cfg_ready, in_ready, wen, wadd, win, ren, radd,
               mac_valid, mac_data, mac_last, loaded, busy
    );

endinterface

// File: rtl/weight_mem_ctrl.sv
// rtl/weight_mem_ctrl.sv - sequences weight loading and per-beat reads for one neuron's weight memory
module weight_mem_ctrl
    import weight_mem_ctrl_pkg::*;
#(
    parameter int numWeight    = 3,
    parameter int neuronNo     = 5,
    parameter int layerNo      = 1,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int PRETRAINED   = 0
) (
    input  logic             clk,
    input  logic             rst,
    weight_mem_ctrl_if.slave bus
);

    localparam int                  CNT_W     = addr_bits(numWeight);
    localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(numWeight - 1);
    localparam logic [CFG_ID_W-1:0] LAYER_ID  = CFG_ID_W'(layerNo);
    localparam logic [CFG_ID_W-1:0] NEURON_ID = CFG_ID_W'(neuronNo);
    localparam logic                PRELOAD   = (PRETRAINED != 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     rcnt_q, rcnt_d;
    logic                 loaded_q, loaded_d;

    logic                    wen_q;
    logic [addressWidth-1:0] wadd_q;
    logic [dataWidth-1:0]    win_q;
    logic                    mac_valid_q;
    logic                    mac_last_q;
    logic [dataWidth-1:0]    mac_data_q;

    logic                 match;
    logic                 cfg_hit;
    logic                 busy;
    logic                 cfg_ready;
    logic                 in_ready;
    logic                 in_acc;
    logic                 load_acc;
    logic                 wr_done;
    logic [CNT_W-1:0]     waddr_sel;

    assign match   = (bus.cfg_layer == LAYER_ID) && (bus.cfg_neuron == NEURON_ID);
    // A beat that would actually rewrite weights (pretrained parts drop them)
    assign cfg_hit = bus.cfg_valid && match && !PRELOAD;
    assign busy    = (rcnt_q != '0);

    // Handshake decode: weights are frozen mid-vector, and an idle matching cfg beat beats an input beat
    always_comb begin
        cfg_ready = !busy;
        in_ready  = loaded_q && !(cfg_hit && !busy) && (state_q != LOAD);
        in_acc    = bus.in_valid && in_ready;
        load_acc  = cfg_hit && cfg_ready;
        waddr_sel = (state_q == LOAD) ? wcnt_q : '0;
        wr_done   = load_acc && (waddr_sel == LAST_IDX);
    end

    // Next-state: load sequencing and read-address stepping
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        loaded_d = loaded_q;
        rcnt_d   = rcnt_q;
        if (load_acc) begin
            if (wr_done) begin
                state_d  = IDLE;
                wcnt_d   = '0;
                loaded_d = 1'b1;
            end else begin
                state_d  = LOAD;
                wcnt_d   = waddr_sel + CNT_W'(1);
                loaded_d = 1'b0;
            end
        end
        if (in_acc) begin
            rcnt_d = (rcnt_q == LAST_IDX) ? '0 : rcnt_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            loaded_q <= PRELOAD;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            loaded_q <= loaded_d;
        end
    end

    // Registered write port: one-cycle strobe the cycle after a weight is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q  <= 1'b0;
            wadd_q <= '0;
            win_q  <= '0;
        end else begin
            wen_q <= load_acc;
            if (load_acc) begin
                wadd_q <= addressWidth'(waddr_sel);
                win_q  <= bus.cfg_data;
            end
        end
    end

    // MAC-side stream delayed one cycle to line up with the memory's registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_data_q  <= '0;
        end else begin
            mac_valid_q <= in_acc;
            mac_last_q  <= in_acc && (rcnt_q == LAST_IDX);
            if (in_acc) begin
                mac_data_q <= bus.in_data;
            end
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.in_ready  = in_ready;
    assign bus.wen       = wen_q;
    assign bus.wadd      = wadd_q;
    assign bus.win       = win_q;
    assign bus.ren       = in_acc;
    assign bus.radd      = addressWidth'(rcnt_q);
    assign bus.mac_valid = mac_valid_q;
    assign bus.mac_data  = mac_data_q;
    assign bus.mac_last  = mac_last_q;
    assign bus.loaded    = loaded_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// tb/tb_weight_mem_ctrl.sv - randomized self-checking bench for weight_mem_ctrl against a behavioural model
module tb_weight_mem_ctrl;

    localparam int NW     = 3;
    localparam int NEURON = 5;
    localparam int LAYER  = 1;
    localparam int AW     = 10;
    localparam int DW     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_mem_ctrl_if #(.addressWidth(AW), .dataWidth(DW)) bus ();
    weight_mem_ctrl_if #(.addressWidth(AW), .dataWidth(DW)) p_bus ();

    weight_mem_ctrl #(
        .numWeight(NW), .neuronNo(NEURON), .layerNo(LAYER),
        .addressWidth(AW), .dataWidth(DW), .PRETRAINED(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    weight_mem_ctrl #(
        .numWeight(NW), .neuronNo(NEURON), .layerNo(LAYER),
        .addressWidth(AW), .dataWidth(DW), .PRETRAINED(1)
    ) p_dut (
        .clk(clk),
        .rst(rst),
        .bus(p_bus)
    );

    assign p_bus.cfg_valid  = bus.cfg_valid;
    assign p_bus.cfg_layer  = bus.cfg_layer;
    assign p_bus.cfg_neuron = bus.cfg_neuron;
    assign p_bus.cfg_data   = bus.cfg_data;
    assign p_bus.in_valid   = bus.in_valid;
    assign p_bus.in_data    = bus.in_data;

    // Stand-in weight memory: registered write and registered read
    logic [DW-1:0] wmem [0:7];
    logic [DW-1:0] wout;
    always @(posedge clk) begin
        if (bus.wen) wmem[bus.wadd[2:0]] <= bus.win;
        if (bus.ren) wout <= wmem[bus.radd[2:0]];
    end

    int p_wen_cnt = 0;
    always @(posedge clk) if (p_bus.wen) p_wen_cnt <= p_wen_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: position in the reload (-1 when not reloading), position in the input vector
    int            m_wpos;
    int            m_rpos;
    bit            m_loaded;
    logic [DW-1:0] m_w [NW];
    bit            e_wen, e_mv, e_ml;
    int            e_wadd;
    logic [DW-1:0] e_win, e_md, e_wout;

    task automatic drive(input bit cv, input int layer, input int neuron, input int cd,
                         input bit iv, input int id);
        bus.cfg_valid  = cv;
        bus.cfg_layer  = 8'(layer);
        bus.cfg_neuron = 8'(neuron);
        bus.cfg_data   = DW'(cd);
        bus.in_valid   = iv;
        bus.in_data    = DW'(id);
    endtask

    task automatic drive_idle();
        drive(1'b0, 0, 0, 0, 1'b0, 0);
    endtask

    task automatic model_reset();
        m_wpos   = -1;
        m_rpos   = 0;
        m_loaded = 1'b0;
        e_wen    = 1'b0;
        e_mv     = 1'b0;
        e_ml     = 1'b0;
    endtask

    // One clock: check handshake outputs, advance the model, then check registered outputs
    task automatic cycle();
        bit hit, busy_e, ir_e, ren_e, cacc;
        int addr;
        #1;
        hit    = (bus.cfg_layer == 8'(LAYER)) && (bus.cfg_neuron == 8'(NEURON));
        busy_e = (m_rpos != 0);
        ir_e   = m_loaded && !(bus.cfg_valid && hit && !busy_e) && (m_wpos < 0);
        ren_e  = bus.in_valid && ir_e;
        check_eq("cfg_ready", bus.cfg_ready, !busy_e);
        check_eq("in_ready", bus.in_ready, ir_e);
        check_eq("busy", bus.busy, busy_e);
        check_eq("ren", bus.ren, ren_e);
        if (ren_e) check_eq("radd", bus.radd, m_rpos);

        cacc  = bus.cfg_valid && hit && !busy_e;
        e_wen = cacc;
        if (cacc) begin
            addr      = (m_wpos < 0) ? 0 : m_wpos;
            m_w[addr] = bus.cfg_data;
            e_wadd    = addr;
            e_win     = bus.cfg_data;
            m_loaded  = 1'b0;
            m_wpos    = addr + 1;
            if (m_wpos == NW) begin
                m_loaded = 1'b1;
                m_wpos   = -1;
            end
        end
        e_mv = ren_e;
        e_ml = 1'b0;
        if (ren_e) begin
            e_md   = bus.in_data;
            e_ml   = (m_rpos == NW - 1);
            e_wout = m_w[m_rpos];
            m_rpos = (m_rpos + 1) % NW;
        end

        @(posedge clk);
        @(negedge clk);
        check_eq("wen", bus.wen, e_wen);
        if (e_wen) begin
            check_eq("wadd", bus.wadd, e_wadd);
            check_eq("win", bus.win, e_win);
        end
        check_eq("mac_valid", bus.mac_valid, e_mv);
        check_eq("mac_last", bus.mac_last, e_ml);
        if (e_mv) begin
            check_eq("mac_data", bus.mac_data, e_md);
            check_eq("wout", wout, e_wout);
        end
        check_eq("loaded", bus.loaded, m_loaded);
    endtask

    // Async reset raised between edges; outputs must settle without a clock edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_wen", bus.wen, 0);
        check_eq("rst_wadd", bus.wadd, 0);
        check_eq("rst_win", bus.win, 0);
        check_eq("rst_ren", bus.ren, 0);
        check_eq("rst_radd", bus.radd, 0);
        check_eq("rst_mac_valid", bus.mac_valid, 0);
        check_eq("rst_mac_last", bus.mac_last, 0);
        check_eq("rst_mac_data", bus.mac_data, 0);
        check_eq("rst_loaded", bus.loaded, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_p_loaded", p_bus.loaded, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load3(input int a, input int b, input int c);
        drive(1'b1, LAYER, NEURON, a, 1'b0, 0); cycle();
        drive(1'b1, LAYER, NEURON, b, 1'b0, 0); cycle();
        drive(1'b1, LAYER, NEURON, c, 1'b0, 0); cycle();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) wmem[i] = '0;
        drive_idle();
        model_reset();
        do_reset();

        drive_idle();
        #1;
        check_eq("p_in_ready_idle", p_bus.in_ready, 1);
        cycle();

        // Initial weight load
        load3(16'h11, 16'h22, 16'h33);
        drive_idle(); cycle();
        check_eq("loaded_after_load", bus.loaded, 1);

        // Beats for another neuron / layer are acked and dropped
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, LAYER, 4, $urandom, 1'b0, 0); cycle();
        end
        drive(1'b1, 2, NEURON, $urandom, 1'b0, 0); cycle();

        // Two back-to-back vectors
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 0, 0, 0, 1'b1, $urandom); cycle();
        end
        drive_idle(); cycle();

        // Reload request arrives mid-vector: stalls until the vector ends
        drive(1'b0, 0, 0, 0, 1'b1, $urandom); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, LAYER, NEURON, $urandom, 1'b1, $urandom); cycle();
        end
        check_eq("loaded_cleared", bus.loaded, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, LAYER, NEURON, $urandom, 1'b1, $urandom); cycle();
        end
        drive_idle(); cycle();

        // Simultaneous cfg and input beat while idle: cfg wins
        drive(1'b1, LAYER, NEURON, 16'h5a5a, 1'b1, $urandom); cycle();
        drive(1'b1, LAYER, NEURON, $urandom, 1'b0, 0); cycle();
        drive(1'b1, LAYER, NEURON, $urandom, 1'b0, 0); cycle();

        // Reset mid-load, then full reload and reset mid-vector
        drive(1'b1, LAYER, NEURON, $urandom, 1'b0, 0); cycle();
        do_reset();
        load3($urandom, $urandom, $urandom);
        drive(1'b0, 0, 0, 0, 1'b1, $urandom); cycle();
        drive(1'b0, 0, 0, 0, 1'b1, $urandom); cycle();
        drive_idle();
        do_reset();
        load3(16'h0101, 16'h0202, 16'h0303);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom % 4) == 0,
                  (($urandom % 6) == 0) ? int'($urandom % 4) : LAYER,
                  (($urandom % 6) == 0) ? int'($urandom % 8) : NEURON,
                  $urandom,
                  ($urandom % 4) != 0,
                  $urandom);
            cycle();
            if (($urandom % 250) == 0) do_reset();
        end

        drive_idle(); cycle();
        check_eq("p_no_writes", p_wen_cnt, 0);
        check_eq("p_loaded_end", p_bus.loaded, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
